// File: rtl/aes_pkg.sv
// Shared AES SubBytes definitions: FIPS-197 forward/inverse S-box tables,
// a byte-select helper and the engine FSM state encoding.
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [0:255] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Byte idx of a 128-bit state; byte 0 is the least significant.
   function automatic logic [7:0] get_byte(input logic [127:0] s, input logic [3:0] idx);
      return s[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lane: forward or inverse substitution of a byte.
module sbox_lane
   import aes_pkg::*;
(
   input  logic [7:0] byte_i,
   input  logic       inv_i,
   output logic [7:0] byte_o
);

   assign byte_o = inv_i ? INV_SBOX[byte_i] : SBOX[byte_i];

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes/InvSubBytes over a 128-bit state, LANES bytes per
// clock, with valid/ready handshakes on input and output.
module sub_bytes_engine
   import aes_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   localparam int NSTEP = 16 / LANES;
   localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
   end

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; valid never waits on ready, and DONE holds out_state steady.
   state_e             state_q;
   logic [127:0]       work_q, work_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               inv_q;
   logic               in_ready_q, out_valid_q, busy_q;

   logic [3:0] lane_idx [LANES];
   logic [7:0] lane_in  [LANES];
   logic [7:0] lane_out [LANES];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_idx[l] = 4'((int'(cnt_q) * LANES) + l);
      assign lane_in[l]  = get_byte(work_q, lane_idx[l]);

      sbox_lane u_lane (
         .byte_i (lane_in[l]),
         .inv_i  (inv_q),
         .byte_o (lane_out[l])
      );
   end

   always_comb begin
      work_d = work_q;
      for (int l = 0; l < LANES; l++) begin
         work_d[{lane_idx[l], 3'b000} +: 8] = lane_out[l];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         work_q      <= '0;
         cnt_q       <= '0;
         inv_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  work_q     <= in_state;
                  inv_q      <= in_inv;
                  cnt_q      <= '0;
                  state_q    <= BUSY;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            BUSY: begin
               work_q <= work_d;
               if (cnt_q == CNT_W'(NSTEP - 1)) begin
                  cnt_q       <= '0;
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_state = work_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Scoreboard bench for sub_bytes_engine at LANES = 4, 1 and 16, checked
// against an S-box model built from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
   localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;

   logic [7:0] fwd_tab [256];
   logic [7:0] inv_tab [256];
   bit model_ready = 1'b0;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   initial begin
      for (int b = 0; b < 256; b++) begin
         logic [7:0] y = 8'h00;
         logic [7:0] s;
         for (int c = 1; c < 256; c++)
            if (gf_mul(8'(b), 8'(c)) == 8'h01) y = 8'(c);
         s = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
         fwd_tab[b] = s;
         inv_tab[s] = 8'(b);
      end
      model_ready = 1'b1;
   end

   function automatic logic [127:0] model(input logic [127:0] d, input bit inv);
      logic [127:0] r;
      for (int j = 0; j < 16; j++)
         r[8*j +: 8] = inv ? inv_tab[d[8*j +: 8]] : fwd_tab[d[8*j +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic chk(input int lanes, input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL L%0d %s: got %0h expected %0h", lanes, name, act, exp);
      end
   endtask

   task automatic fail(input int lanes, input string name);
      n_tests++;
      n_fail++;
      $display("FAIL L%0d %s: event did not match expectation", lanes, name);
   endtask

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      localparam int LP = (g == 0) ? 4 : (g == 1) ? 1 : 16;
      localparam int NS = 16 / LP;
      localparam int ABORT_WAIT = (NS >= 3) ? 2 : 0;

      logic         reset, in_valid, in_ready, in_inv, out_valid, out_ready, busy;
      logic [127:0] in_state, out_state;
      bit           rand_ready  = 1'b0;
      bit           force_ready = 1'b1;
      bit           done        = 1'b0;

      logic [127:0] exp_q [$];
      int           acc_q [$];

      sub_bytes_engine #(.LANES(LP)) dut (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .in_state  (in_state),
         .in_inv    (in_inv),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .out_state (out_state),
         .busy      (busy)
      );

      always @(posedge clk) begin
         #1 out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
      end

      // Monitor: samples on the falling edge, pops on every output transfer.
      bit           prev_v = 1'b0, prev_hs = 1'b0, prev_stall = 1'b0;
      logic [127:0] prev_s = '0;
      always @(negedge clk) begin
         int a;
         if (prev_hs) chk(LP, "idle_after_transfer", {in_ready, out_valid, busy}, 3'b100);
         if (out_valid) begin
            if (!prev_v) begin
               if (acc_q.size() == 0) fail(LP, "spurious_out_valid");
               else begin
                  a = acc_q.pop_front();
                  chk(LP, "latency", cyc - a, NS);
               end
            end
            if (prev_stall) chk(LP, "stall_stable", out_state, prev_s);
            chk(LP, "done_flags", {in_ready, busy}, 2'b01);
            if (out_ready) begin
               if (exp_q.size() == 0) fail(LP, "unexpected_output");
               else chk(LP, "out_state", out_state, exp_q.pop_front());
            end
         end
         prev_hs    = out_valid && out_ready;
         prev_stall = out_valid && !out_ready && !reset;
         prev_v     = out_valid;
         prev_s     = out_state;
      end

      task automatic send(input logic [127:0] d, input bit inv, input logic [127:0] e);
         int t = 0;
         in_valid = 1'b1;
         in_state = d;
         in_inv   = inv;
         while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
         end
         if (!in_ready) fail(LP, "accept_timeout");
         else begin
            exp_q.push_back(e);
            acc_q.push_back(cyc + 1);
         end
         @(negedge clk);
         in_valid = 1'b0;
         in_state = rand128();
         in_inv   = ~inv;
      endtask

      task automatic drain();
         int t = 0;
         while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
         end
         if (exp_q.size() != 0) fail(LP, "drain_timeout");
      endtask

      initial begin
         logic [127:0] d;
         int t;
         reset    = 1'b1;
         in_valid = 1'b1;
         in_state = rand128();
         in_inv   = 1'b0;
         wait (model_ready);
         repeat (3) begin
            @(negedge clk);
            chk(LP, "reset_flags", {in_ready, out_valid, busy}, 3'b100);
            chk(LP, "reset_out_state", out_state, '0);
         end
         reset    = 1'b0;
         in_valid = 1'b0;
         repeat (NS + 3) @(negedge clk);

         // Known-answer vectors and single-byte corners.
         send(FIPS_IN, 1'b0, FIPS_OUT);
         drain();
         send(FIPS_OUT, 1'b1, FIPS_IN);
         send({16{8'h63}}, 1'b1, '0);
         send({16{8'h53}}, 1'b0, {16{8'hed}});
         send({16{8'hed}}, 1'b1, {16{8'h53}});
         drain();

         // Backpressure in DONE with competing input traffic.
         force_ready = 1'b0;
         d = rand128();
         send(d, 1'b0, model(d, 1'b0));
         t = 0;
         while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
         end
         if (!out_valid) fail(LP, "bp_valid_timeout");
         for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            in_state = rand128();
            in_inv   = 1'(i);
            @(negedge clk);
            chk(LP, "bp_in_ready", in_ready, 1'b0);
            chk(LP, "bp_out_valid", out_valid, 1'b1);
         end
         in_valid    = 1'b0;
         force_ready = 1'b1;
         drain();
         repeat (NS + 3) @(negedge clk);

         // Abort mid-substitution.
         d = rand128();
         send(d, 1'b0, model(d, 1'b0));
         repeat (ABORT_WAIT) @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         chk(LP, "abort_flags", {in_ready, out_valid, busy}, 3'b100);
         chk(LP, "abort_out_state", out_state, '0);
         void'(exp_q.pop_back());
         void'(acc_q.pop_back());
         reset = 1'b0;
         repeat (NS + 2) @(negedge clk);
         d = rand128();
         send(d, 1'b1, model(d, 1'b1));
         drain();

         // All 256 byte values forward then back, then random traffic.
         rand_ready = 1'b1;
         for (int s = 0; s < 16; s++) begin
            for (int j = 0; j < 16; j++) d[8*j +: 8] = 8'(s * 16 + j);
            send(d, 1'b0, model(d, 1'b0));
            send(model(d, 1'b0), 1'b1, d);
         end
         for (int i = 0; i < 20; i++) begin
            bit inv = 1'($urandom_range(0, 1));
            d = rand128();
            send(d, inv, model(d, inv));
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         drain();
         rand_ready  = 1'b0;
         force_ready = 1'b1;
         repeat (NS + 4) @(negedge clk);
         chk(LP, "queue_empty", exp_q.size(), 0);
         done = 1'b1;
      end
   end

   initial begin
      int t = 0;
      while (!(gen_dut[0].done && gen_dut[1].done && gen_dut[2].done) && t < 60000) begin
         @(negedge clk);
         t++;
      end
      if (!(gen_dut[0].done && gen_dut[1].done && gen_dut[2].done)) fail(0, "global_timeout");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
